// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Holds the FSM encoding, default data width and operand slice helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mul_state_t;

    localparam int MUL_DATA_W = 32;

    // Base bit of requester idx within a packed operand bus.
    function automatic int op_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Round-robin first-one finder: search req_valid upward from rr_ptr.
// Ports: req_valid, rr_ptr in; grant_oh (one-hot or 0), grant_idx out.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier among NUM_REQ requesters (round-robin).
// Ports: req_* / rsp_* per-requester channels, mul_* multiplier side.
// Optional: define MUL_ARB_ZERO_BYPASS_EN to answer zero-operand ops directly.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = MUL_DATA_W,
    parameter int PTR_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_res,
    output logic                      rsp_overflow,
    output logic                      mul_en,
    output logic [DATA_W-1:0]         mul_op1,
    output logic [DATA_W-1:0]         mul_op2,
    input  logic [DATA_W-1:0]         mul_res,
    input  logic                      mul_val,
    input  logic                      mul_overflow
);

    mul_state_t         state_q;
    mul_state_t         state_d;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  sel_op1;
    logic [DATA_W-1:0]  sel_op2;
    logic               hs;
    logic               byp;
    logic               rsp_done;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx)
    );

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_op1 = req_op1[op_lsb(i, DATA_W) +: DATA_W];
                sel_op2 = req_op2[op_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    assign hs = (state_q == IDLE) && (|pick_oh);

`ifdef MUL_ARB_ZERO_BYPASS_EN
    assign byp = (sel_op1 == '0) || (sel_op2 == '0);
`else
    assign byp = 1'b0;
`endif

    assign rsp_done = (state_q == RESP) && rsp_ready[grant];

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        mul_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = pick_oh;
                if (hs) state_d = byp ? RESP : ISSUE;
            end
            ISSUE: begin
                mul_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_val) state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant] = 1'b1;
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            mul_op1      <= '0;
            mul_op2      <= '0;
            rsp_res      <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                grant   <= pick_idx;
                mul_op1 <= sel_op1;
                mul_op2 <= sel_op2;
                if (byp) begin
                    rsp_res      <= '0;
                    rsp_overflow <= 1'b0;
                end
            end
            // mul_val outside WAIT is stale or spurious
            if ((state_q == WAIT) && mul_val) begin
                rsp_res      <= mul_res;
                rsp_overflow <= mul_overflow;
            end
            if (rsp_done) begin
                if (grant == PTR_W'(NUM_REQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant + PTR_W'(1);
            end
        end
    end

endmodule
